// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for a small register file.
// Two requesters (A: ALU writeback, B: immediate/load unit) share one
// registered write port. Out-of-range addresses are granted but suppressed,
// with a sticky error flag; simultaneous requests are counted (saturating).
module regfile_write_arbiter #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 4,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_gnt,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              addr_err,
    output logic [CNT_W-1:0]  collisions
);

    // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic {
        PRI_A,
        PRI_B
    } pri_t;

    pri_t              pri_q;
    pri_t              pri_d;
    logic              grant;
    logic              win_bad;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Priority pointer register: starts at A after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pri_q <= PRI_A;
        end else begin
            pri_q <= pri_d;
        end
    end

    // Grant decision and next pointer: the loser of a grant gets priority next.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        pri_d = pri_q;
        if (reset_n) begin
            if (a_req && (!b_req || pri_q == PRI_A)) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
        if (a_gnt) begin
            pri_d = PRI_B;
        end else if (b_gnt) begin
            pri_d = PRI_A;
        end
    end

    // Winner payload selection and range check.
    always_comb begin
        grant    = a_gnt | b_gnt;
        win_addr = a_gnt ? a_addr : b_addr;
        win_data = a_gnt ? a_data : b_data;
        win_bad  = {1'b0, win_addr} >= REG_LIMIT;
    end

    // Registered write port: address/data hold when no legal write is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else if (grant && !win_bad) begin
            rf_we   <= 1'b1;
            rf_addr <= win_addr;
            rf_data <= win_data;
        end else begin
            rf_we   <= 1'b0;
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_err <= 1'b0;
        end else if (grant && win_bad) begin
            addr_err <= 1'b1;
        end
    end

    // Saturating count of cycles where both requesters are active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            collisions <= '0;
        end else if (a_req && b_req && collisions != '1) begin
            collisions <= collisions + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized self-checking bench for regfile_write_arbiter with a
// cycle-level behavioural model of arbitration, write port and counters.
module tb_regfile_write_arbiter;

    logic       clk;
    logic       reset_n;
    logic       a_req;
    logic [3:0] a_addr;
    logic [3:0] a_data;
    logic       a_gnt;
    logic       b_req;
    logic [3:0] b_addr;
    logic [3:0] b_data;
    logic       b_gnt;
    logic       rf_we;
    logic [3:0] rf_addr;
    logic [3:0] rf_data;
    logic       addr_err;
    logic [7:0] collisions;

    // Second instance with a 2-bit counter to exercise saturation.
    logic       s_a_gnt;
    logic       s_b_gnt;
    logic       s_rf_we;
    logic [3:0] s_rf_addr;
    logic [3:0] s_rf_data;
    logic       s_addr_err;
    logic [1:0] s_collisions;

    regfile_write_arbiter #(
        .DATA_W  (4),
        .ADDR_W  (4),
        .NUM_REGS(4),
        .CNT_W   (8)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_gnt     (a_gnt),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_gnt     (b_gnt),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .addr_err  (addr_err),
        .collisions(collisions)
    );

    regfile_write_arbiter #(
        .DATA_W  (4),
        .ADDR_W  (4),
        .NUM_REGS(4),
        .CNT_W   (2)
    ) u_dut_sat (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_gnt     (s_a_gnt),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_gnt     (s_b_gnt),
        .rf_we     (s_rf_we),
        .rf_addr   (s_rf_addr),
        .rf_data   (s_rf_data),
        .addr_err  (s_addr_err),
        .collisions(s_collisions)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state.
    bit         m_prefer_b;
    bit         m_we;
    bit [3:0]   m_addr;
    bit [3:0]   m_data;
    bit         m_err;
    int         m_col;
    int         m_col2;
    bit [3:0]   m_rf [16];
    logic [3:0] obs_rf [16];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prefer_b = 1'b0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_data     = '0;
        m_err      = 1'b0;
        m_col      = 0;
        m_col2     = 0;
    endtask

    task automatic check_regs();
        check_eq("rf_we",        rf_we,        m_we);
        check_eq("rf_addr",      rf_addr,      m_addr);
        check_eq("rf_data",      rf_data,      m_data);
        check_eq("addr_err",     addr_err,     m_err);
        check_eq("collisions",   collisions,   m_col);
        check_eq("collisions_2", s_collisions, m_col2);
    endtask

    // Called just after a posedge: drive, check grants, advance model, check registers.
    task automatic cycle(input bit ar, input bit [3:0] aa, input bit [3:0] ad,
                         input bit br, input bit [3:0] ba, input bit [3:0] bd,
                         output bit ga, output bit gb);
        bit [3:0] wa;
        bit [3:0] wd;
        a_req = ar; a_addr = aa; a_data = ad;
        b_req = br; b_addr = ba; b_data = bd;
        #1;
        ga = ar && (!br || !m_prefer_b);
        gb = br && !ga;
        check_eq("a_gnt", a_gnt, ga);
        check_eq("b_gnt", b_gnt, gb);
        wa = ga ? aa : ba;
        wd = ga ? ad : bd;
        m_we = 1'b0;
        if (ga || gb) begin
            m_prefer_b = ga;
            if (wa < 4) begin
                m_we     = 1'b1;
                m_addr   = wa;
                m_data   = wd;
                m_rf[wa] = wd;
            end else begin
                m_err = 1'b1;
            end
        end
        if (ar && br) begin
            m_col  = (m_col  < 255) ? m_col  + 1 : 255;
            m_col2 = (m_col2 < 3)   ? m_col2 + 1 : 3;
        end
        @(posedge clk);
        #1;
        check_regs();
        if (rf_we === 1'b1) obs_rf[rf_addr] = rf_data;
    endtask

    // Asynchronous reset asserted mid-cycle, released after the next edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_a_gnt", a_gnt, 1'b0);
        check_eq("rst_b_gnt", b_gnt, 1'b0);
        check_regs();
        @(posedge clk);
        #1;
        check_regs();
        reset_n = 1'b1;
    endtask

    bit       ga, gb;
    bit       pa, pb;
    bit [3:0] pa_addr, pa_data, pb_addr, pb_data;

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_rf[i]   = '0;
            obs_rf[i] = '0;
        end
        reset_n = 1'b0;
        a_req = 1'b0; a_addr = '0; a_data = '0;
        b_req = 1'b0; b_addr = '0; b_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        reset_n = 1'b1;

        // Reset mid-write: staged A write must be discarded, pointer back to A.
        a_req = 1'b1; a_addr = 4'd2; a_data = 4'd5;
        #1;
        check_eq("t1_a_gnt", a_gnt, 1'b1);
        #2;
        a_req = 1'b0;
        do_reset();
        check_eq("t1_reg2_untouched", obs_rf[2], 4'd0);
        cycle(1, 4'd0, 4'd1, 1, 4'd1, 4'd2, ga, gb);
        check_eq("t1_ptr_a", ga, 1'b1);
        cycle(0, 0, 0, 0, 0, 0, ga, gb);

        // Solo A request.
        cycle(1, 4'd1, 4'd9, 0, 0, 0, ga, gb);
        check_eq("t2_rf_addr", rf_addr, 4'd1);
        check_eq("t2_rf_data", rf_data, 4'd9);

        // Four cycles of contention: A,B,A,B. Start from a clean counter.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 4'd0, 4'd3, 1, 4'd3, 4'd6, ga, gb);
        check_eq("t3_collisions", collisions, 8'd4);
        check_eq("t3_last_b", gb, 1'b1);

        // Same register from both sides: last granted write wins.
        cycle(1, 4'd2, 4'd1, 1, 4'd2, 4'd7, ga, gb);
        cycle(0, 0, 0, 1, 4'd2, 4'd7, ga, gb);
        cycle(0, 0, 0, 0, 0, 0, ga, gb);
        check_eq("t4_reg2", obs_rf[2], 4'd7);

        // Bad address from B, then contention must favour A.
        cycle(0, 0, 0, 1, 4'd5, 4'd4, ga, gb);
        check_eq("t5_err", addr_err, 1'b1);
        cycle(1, 4'd1, 4'd3, 1, 4'd0, 4'd8, ga, gb);
        check_eq("t5_a_wins", ga, 1'b1);
        cycle(0, 0, 0, 1, 4'd0, 4'd8, ga, gb);

        // Saturation of the 2-bit counter instance.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 4'd3, 4'd2, 1, 4'd1, 4'd4, ga, gb);
        check_eq("t6_sat", s_collisions, 2'd3);
        check_eq("t6_wide", collisions, 8'd6);

        // Randomized traffic; requesters hold their request until granted.
        pa = 0; pb = 0;
        pa_addr = '0; pa_data = '0; pb_addr = '0; pb_data = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pa && $urandom_range(0, 99) < 60) begin
                pa = 1;
                pa_addr = ($urandom_range(0, 9) < 2) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
                pa_data = 4'($urandom);
            end
            if (!pb && $urandom_range(0, 99) < 60) begin
                pb = 1;
                pb_addr = ($urandom_range(0, 9) < 2) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
                pb_data = 4'($urandom);
            end
            if ($urandom_range(0, 99) == 0) begin
                a_req = 1'b0;
                b_req = 1'b0;
                do_reset();
            end else begin
                cycle(pa, pa_addr, pa_data, pb, pb_addr, pb_data, ga, gb);
                if (ga) pa = 0;
                if (gb) pb = 0;
            end
        end
        cycle(0, 0, 0, 0, 0, 0, ga, gb);
        for (int i = 0; i < 4; i++) check_eq("final_reg", obs_rf[i], m_rf[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
